// File: rtl/chip_bus_slot_arbiter.sv
// chip_bus_slot_arbiter: per-CCK chip-bus slot owner selection with CPU bus-request and starve override.
// Optional CPU stall statistics are enabled by defining CHIP_BUS_STALL_STATS_EN.
module chip_bus_slot_arbiter #(
    parameter logic [7:0] SLOT_DSK0  = 8'h09,
    parameter logic [7:0] SLOT_AUD0  = 8'h0F,
    parameter logic [7:0] SLOT_SPR0  = 8'h17,
    parameter logic [1:0] STARVE_MAX = 2'd2
) (
    input  logic       main_clk,
    input  logic       main_rst,
    input  logic       cck_rise,
    input  logic [7:0] hpos,
    input  logic [9:0] dmacon,
    input  logic       blt_pri,
    input  logic       dsk_req,
    input  logic [3:0] aud_req,
    input  logic [7:0] spr_req,
    input  logic       bpl_req,
    input  logic       cop_req,
    input  logic       blt_req,
    input  logic       cpu_req,
    output logic       grant_vld,
    output logic [3:0] grant_owner,
    output logic [2:0] grant_idx,
    output logic       cpu_dbr_n
`ifdef CHIP_BUS_STALL_STATS_EN
    ,
    output logic [7:0] cpu_stall_cnt,
    output logic [7:0] cpu_stall_line
`endif
);

    typedef enum logic [3:0] {
        OWN_IDLE = 4'd0,
        OWN_REF  = 4'd1,
        OWN_DSK  = 4'd2,
        OWN_AUD  = 4'd3,
        OWN_SPR  = 4'd4,
        OWN_BPL  = 4'd5,
        OWN_COP  = 4'd6,
        OWN_BLT  = 4'd7,
        OWN_CPU  = 4'd8
    } owner_e;

    owner_e      own, owner_d, owner_q;
    logic [2:0]  idx, idx_d, idx_q;
    logic        vld_d, vld_q;
    logic        dbr_n_d, dbr_n_q;
    logic [1:0]  starve_d, starve_q;
    logic        stall;
    logic        dma_en, blt_en;
    logic [7:0]  dsk_off, aud_off, spr_off;
    logic        is_dsk, is_aud, is_spr;
    logic [1:0]  aud_n;
    logic [2:0]  spr_n;

    // Slot offsets from each fixed group; odd-only groups step by 2 (disk, audio) or 4 per sprite.
    assign dma_en  = dmacon[9];
    assign blt_en  = dma_en && dmacon[6] && blt_req;
    assign dsk_off = hpos - SLOT_DSK0;
    assign aud_off = hpos - SLOT_AUD0;
    assign spr_off = hpos - SLOT_SPR0;
    assign is_dsk  = (dsk_off <= 8'd4) && !dsk_off[0];
    assign is_aud  = (aud_off <= 8'd6) && !aud_off[0];
    assign is_spr  = (spr_off <= 8'd30) && !spr_off[0];
    assign aud_n   = aud_off[2:1];
    assign spr_n   = spr_off[4:2];

    // Fixed-priority owner for the slot at hpos; disabled fixed slots fall through.
    always_comb begin
        own = OWN_IDLE;
        idx = '0;
        if (hpos[7:3] == 5'd0 && hpos[0]) begin
            own = OWN_REF;
        end else if (is_dsk && dma_en && dmacon[4] && dsk_req) begin
            own = OWN_DSK;
        end else if (is_aud && dma_en && dmacon[aud_n] && aud_req[aud_n]) begin
            own = OWN_AUD;
            idx = {1'b0, aud_n};
        end else if (bpl_req && dma_en && dmacon[8]) begin
            own = OWN_BPL;
        end else if (is_spr && dma_en && dmacon[5] && spr_req[spr_n]) begin
            own = OWN_SPR;
            idx = spr_n;
        end else if (!hpos[0] && dma_en && dmacon[7] && cop_req) begin
            own = OWN_COP;
        end else if (cpu_req && !blt_pri && starve_q == STARVE_MAX) begin
            own = OWN_CPU;
        end else if (blt_en) begin
            own = OWN_BLT;
        end else if (cpu_req) begin
            own = OWN_CPU;
        end
    end

    assign stall = cpu_req && (own != OWN_CPU);

    // Latch the slot decision only on the CCK strobe; hold otherwise.
    always_comb begin
        owner_d  = cck_rise ? own : owner_q;
        idx_d    = cck_rise ? idx : idx_q;
        vld_d    = cck_rise ? (own != OWN_IDLE) : vld_q;
        dbr_n_d  = cck_rise ? !stall : dbr_n_q;
        starve_d = !cck_rise ? starve_q :
                   !stall ? 2'd0 :
                   (starve_q == STARVE_MAX) ? starve_q : starve_q + 2'd1;
    end

    // Grant and starve registers with synchronous active-low reset.
    always_ff @(posedge main_clk) begin
        if (!main_rst) begin
            owner_q  <= OWN_IDLE;
            idx_q    <= '0;
            vld_q    <= 1'b0;
            dbr_n_q  <= 1'b1;
            starve_q <= '0;
        end else begin
            owner_q  <= owner_d;
            idx_q    <= idx_d;
            vld_q    <= vld_d;
            dbr_n_q  <= dbr_n_d;
            starve_q <= starve_d;
        end
    end

    assign grant_vld   = vld_q;
    assign grant_owner = owner_q;
    assign grant_idx   = idx_q;
    assign cpu_dbr_n   = dbr_n_q;

`ifdef CHIP_BUS_STALL_STATS_EN
    logic [7:0] cnt_d, cnt_q, line_d, line_q;

    // Per-line stall count: snapshot at the hpos==0 slot, then restart including that slot.
    always_comb begin
        cnt_d  = cnt_q;
        line_d = line_q;
        if (cck_rise && hpos == 8'd0) begin
            line_d = cnt_q;
            cnt_d  = {7'd0, stall};
        end else if (cck_rise && stall && cnt_q != 8'hFF) begin
            cnt_d  = cnt_q + 8'd1;
        end
    end

    // Stall statistic registers.
    always_ff @(posedge main_clk) begin
        if (!main_rst) begin
            cnt_q  <= '0;
            line_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            line_q <= line_d;
        end
    end

    assign cpu_stall_cnt  = cnt_q;
    assign cpu_stall_line = line_q;
`endif

endmodule

// File: tb/tb_chip_bus_slot_arbiter.sv
// tb_chip_bus_slot_arbiter: scoreboard bench with a slot-list reference model and randomized slots.
module tb_chip_bus_slot_arbiter;

    logic       main_clk = 1'b0;
    logic       main_rst = 1'b0;
    logic       cck_rise = 1'b0;
    logic [7:0] hpos     = '0;
    logic [9:0] dmacon   = '0;
    logic       blt_pri  = 1'b0;
    logic       dsk_req  = 1'b0;
    logic [3:0] aud_req  = '0;
    logic [7:0] spr_req  = '0;
    logic       bpl_req  = 1'b0;
    logic       cop_req  = 1'b0;
    logic       blt_req  = 1'b0;
    logic       cpu_req  = 1'b0;
    logic       grant_vld;
    logic [3:0] grant_owner;
    logic [2:0] grant_idx;
    logic       cpu_dbr_n;
`ifdef CHIP_BUS_STALL_STATS_EN
    logic [7:0] cpu_stall_cnt, cpu_stall_line;
`endif

    chip_bus_slot_arbiter dut (
        .main_clk(main_clk), .main_rst(main_rst), .cck_rise(cck_rise), .hpos(hpos),
        .dmacon(dmacon), .blt_pri(blt_pri), .dsk_req(dsk_req), .aud_req(aud_req),
        .spr_req(spr_req), .bpl_req(bpl_req), .cop_req(cop_req), .blt_req(blt_req),
        .cpu_req(cpu_req), .grant_vld(grant_vld), .grant_owner(grant_owner),
        .grant_idx(grant_idx), .cpu_dbr_n(cpu_dbr_n)
`ifdef CHIP_BUS_STALL_STATS_EN
        , .cpu_stall_cnt(cpu_stall_cnt), .cpu_stall_line(cpu_stall_line)
`endif
    );

    always #5 main_clk = ~main_clk;

    typedef struct {
        int own;
        int idx;
        int vld;
        int dbrn;
        int cnt;
        int line;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state
    int m_own = 0, m_idx = 0, m_vld = 0, m_dbrn = 1, m_starve = 0, m_cnt = 0, m_line = 0;
    localparam int STARVE_MAX = 2;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Owner from the written priority rules, using explicit slot lists.
    task automatic arbitrate(output int o, output int x);
        int  h;
        bit  dma;
        h   = int'(hpos);
        dma = dmacon[9];
        o   = 0;
        x   = 0;
        if (h == 1 || h == 3 || h == 5 || h == 7) o = 1;
        if (o == 0 && dma && dmacon[4] && dsk_req && (h == 9 || h == 11 || h == 13)) o = 2;
        for (int n = 0; n < 4; n++)
            if (o == 0 && h == 15 + 2 * n && dma && dmacon[n] && aud_req[n]) begin o = 3; x = n; end
        if (o == 0 && bpl_req && dma && dmacon[8]) o = 5;
        for (int n = 0; n < 8; n++)
            if (o == 0 && (h == 23 + 4 * n || h == 25 + 4 * n) && dma && dmacon[5] && spr_req[n]) begin
                o = 4; x = n;
            end
        if (o == 0 && h % 2 == 0 && dma && dmacon[7] && cop_req) o = 6;
        if (o == 0) begin
            bit blt_ok;
            blt_ok = dma && dmacon[6] && blt_req;
            if (blt_pri) o = blt_ok ? 7 : (cpu_req ? 8 : 0);
            else if (cpu_req && m_starve == STARVE_MAX) o = 8;
            else o = blt_ok ? 7 : (cpu_req ? 8 : 0);
        end
    endtask

    // Advance the model by one main_clk edge and queue what the DUT must show after it.
    task automatic step();
        int  o, x;
        bit  st;
        exp_t e;
        if (!main_rst) begin
            m_own = 0; m_idx = 0; m_vld = 0; m_dbrn = 1; m_starve = 0; m_cnt = 0; m_line = 0;
        end else if (cck_rise) begin
            arbitrate(o, x);
            st     = cpu_req && o != 8;
            m_own  = o;
            m_idx  = x;
            m_vld  = (o != 0);
            m_dbrn = st ? 0 : 1;
            m_starve = st ? ((m_starve < STARVE_MAX) ? m_starve + 1 : m_starve) : 0;
            if (hpos == 0) begin
                m_line = m_cnt;
                m_cnt  = st ? 1 : 0;
            end else if (st && m_cnt < 255) m_cnt++;
        end
        e = '{m_own, m_idx, m_vld, m_dbrn, m_cnt, m_line};
        exp_q.push_back(e);
    endtask

    task automatic tick(input bit r, input bit c);
        main_rst = r;
        cck_rise = c;
        step();
        @(negedge main_clk);
    endtask

    task automatic slot();
        tick(1, 1);
        tick(1, 0);
    endtask

    task automatic all_req(input bit v);
        dsk_req = v; aud_req = {4{v}}; spr_req = {8{v}}; bpl_req = v;
        cop_req = v; blt_req = v; cpu_req = v;
    endtask

    task automatic rand_inputs();
        hpos    = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 63));
        dmacon  = 10'($urandom);
        if ($urandom_range(0, 3) != 0) dmacon[9] = 1'b1;
        blt_pri = 1'($urandom);
        dsk_req = 1'($urandom);
        aud_req = 4'($urandom);
        spr_req = 8'($urandom);
        bpl_req = ($urandom_range(0, 3) == 0);
        cop_req = 1'($urandom);
        blt_req = ($urandom_range(0, 3) != 0);
        cpu_req = ($urandom_range(0, 3) != 0);
    endtask

    // Monitor: compares queued expectations a little after each active edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge main_clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("grant_owner", int'(grant_owner), e.own);
                chk("grant_idx", int'(grant_idx), e.idx);
                chk("grant_vld", int'(grant_vld), e.vld);
                chk("cpu_dbr_n", int'(cpu_dbr_n), e.dbrn);
`ifdef CHIP_BUS_STALL_STATS_EN
                chk("cpu_stall_cnt", int'(cpu_stall_cnt), e.cnt);
                chk("cpu_stall_line", int'(cpu_stall_line), e.line);
`endif
            end
        end
    end

    initial begin
        // Reset held through cck_rise with every request active
        all_req(1); dmacon = 10'h3FF; hpos = 8'h03;
        tick(0, 1); tick(0, 1); tick(0, 0);
        // Refresh slot after release
        slot();
        // Audio slot 1 with AUD1EN clear falls through to CPU, then with AUD1EN set
        all_req(0); hpos = 8'h11; aud_req = 4'b0010; cpu_req = 1; dmacon = 10'h201;
        slot();
        dmacon = 10'h203;
        slot();
        // Bitplane steals a sprite slot, then sprite 1 gets it
        all_req(0); hpos = 8'h1B; spr_req = 8'h02; bpl_req = 1; dmacon = 10'h3FF;
        slot();
        bpl_req = 0;
        slot();
        // Copper on even slot beats blitter and CPU
        hpos = 8'h40; cop_req = 1; blt_req = 1; cpu_req = 1;
        slot();
        // Blitter vs CPU starve override, then nasty blitter
        all_req(0); hpos = 8'h41;
        slot();
        blt_req = 1; cpu_req = 1; blt_pri = 0;
        for (int i = 0; i < 4; i++) begin hpos = 8'h41 + 8'(2 * i); slot(); end
        blt_pri = 1;
        for (int i = 0; i < 4; i++) begin hpos = 8'h43 + 8'(2 * i); slot(); end
        // Line statistics: clean hpos 0, ten stalls, clean hpos 0
        all_req(0); hpos = 8'h00;
        slot();
        blt_req = 1; cpu_req = 1; blt_pri = 1;
        for (int i = 0; i < 10; i++) begin hpos = 8'h41 + 8'(2 * i); slot(); end
        all_req(0); hpos = 8'h00;
        slot();
        // Randomized slots with random gaps and noise on inputs between strobes
        for (int i = 0; i < 800; i++) begin
            rand_inputs();
            if (i == 400) begin tick(0, 1); tick(0, 0); end
            tick(1, 1);
            for (int g = $urandom_range(0, 3); g > 0; g--) begin
                rand_inputs();
                tick(1, 0);
            end
        end
        @(negedge main_clk);
        @(negedge main_clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
